// File: rtl/regfile_pkg.sv
// Shared constants and write-port arbitration for the multi-port register file.
// The REGFILE_BYPASS_EN build option is consumed by regfile_mp.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;

  // Upper bounds for the arbitration helper; ports/addresses are zero-extended to these.
  localparam int MAX_WR = 16;
  localparam int MAX_AW = 16;
  localparam int WIDX_W = 4;

  typedef struct packed {
    logic              hit;
    logic [WIDX_W-1:0] idx;
  } wsel_t;

  // Later ports overwrite earlier matches, so the highest enabled index wins.
  function automatic wsel_t win_port(input logic [MAX_WR-1:0]        en,
                                     input logic [MAX_WR*MAX_AW-1:0] addr,
                                     input logic [MAX_AW-1:0]        a);
    wsel_t s;
    s = '0;
    for (int j = 0; j < MAX_WR; j++) begin
      if (en[j] && (addr[j*MAX_AW +: MAX_AW] == a)) begin
        s.hit = 1'b1;
        s.idx = WIDX_W'(j);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared by writeback or flush, with
// set taking priority over both clears and reset over everything.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set,
  input  logic [AW-1:0]        set_addr,
  input  logic [DEPTH-1:0]     clr,
  input  logic                 flush,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_busy
);

  logic [DEPTH-1:0] busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if ((ZERO_REG != 0) && (r == 0))
          busy[r] <= 1'b0;
        else if (set && (set_addr == AW'(r)))
          busy[r] <= 1'b1;
        else if (flush || clr[r])
          busy[r] <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++)
      rd_busy[i] = busy[rd_addr[i*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_busy_o,
  input  logic [NUM_WR-1:0]      wr_en_i,
  input  logic [NUM_WR*AW-1:0]   wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0] wr_data_i,
  input  logic                   sb_set_i,
  input  logic [AW-1:0]          sb_addr_i,
  input  logic                   flush_i
);

  logic [XLEN-1:0]            mem [DEPTH];
  logic [MAX_WR-1:0]          wen_x;
  logic [MAX_WR*MAX_AW-1:0]   waddr_x;
  wsel_t                      wsel [DEPTH];
  logic [DEPTH-1:0]           clr;
  logic [NUM_RD-1:0]          sb_busy;

  always_comb begin
    wen_x   = '0;
    waddr_x = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wen_x[j]                       = wr_en_i[j];
      waddr_x[j*MAX_AW +: MAX_AW]    = MAX_AW'(wr_addr_i[j*AW +: AW]);
    end
  end

  // One arbitration result per register feeds storage, scoreboard clear and bypass.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      wsel[r] = win_port(wen_x, waddr_x, MAX_AW'(r));
      clr[r]  = wsel[r].hit && !((ZERO_REG != 0) && (r == 0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++)
        mem[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++)
        if (clr[r])
          mem[r] <= wr_data_i[int'(wsel[r].idx)*XLEN +: XLEN];
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set      (sb_set_i),
    .set_addr (sb_addr_i),
    .clr      (clr),
    .flush    (flush_i),
    .rd_addr  (rd_addr_i),
    .rd_busy  (sb_busy)
  );

  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    a         = '0;
    d         = '0;
    rd_data_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = rd_addr_i[i*AW +: AW];
      d = mem[a];
`ifdef REGFILE_BYPASS_EN
      if (wsel[a].hit)
        d = wr_data_i[int'(wsel[a].idx)*XLEN +: XLEN];
`endif
      if ((ZERO_REG != 0) && (a == '0))
        d = '0;
      rd_data_o[i*XLEN +: XLEN] = d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // A same-cycle writeback hides the busy bit unless a new issue re-marks it.
  always_comb begin
    logic [AW-1:0] a;
    a         = '0;
    rd_busy_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a            = rd_addr_i[i*AW +: AW];
      rd_busy_o[i] = sb_busy[i] & ~(clr[a] & ~(sb_set_i && (sb_addr_i == a)));
    end
  end
`else
  assign rd_busy_o = sb_busy;
`endif

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, dual-read `register_file`.
- Sits in the decode/writeback stages of the core: decode reads operands and marks destinations busy; writeback writes results.
- Adds per-register busy scoreboard, configurable port counts/width/depth, write-port priority, synchronous reset and flush.

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of architectural registers; power of two, at least 2.
- NUM_RD, 2, number of combinational read ports.
- NUM_WR, 1, number of synchronous write ports.
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy.
- AW (localparam), $clog2(DEPTH), address width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr_i  in  NUM_RD x AW  read addresses.
- rd_data_o  out  NUM_RD x XLEN  read data, combinational.
- rd_busy_o  out  NUM_RD x 1  scoreboard busy bit of each read address, combinational.
- wr_en_i  in  NUM_WR x 1  write enables.
- wr_addr_i  in  NUM_WR x AW  write addresses.
- wr_data_i  in  NUM_WR x XLEN  write data.
- sb_set_i  in  1  mark sb_addr_i busy (destination issued).
- sb_addr_i  in  AW  register to mark busy.
- flush_i  in  1  clear all busy bits; register contents are kept.

Behaviour:
- Reset: with rst=1 at a rising edge, all DEPTH registers become 0 and all busy bits become 0. rst overrides writes, sb_set_i and flush_i in that cycle. Reset mid-operation discards any write presented in that cycle.
- Outputs have no reset value of their own: they are combinational, so the cycle after reset every rd_data_o = 0 and every rd_busy_o = 0.
- Read:
  - rd_data_o[i] = mem[rd_addr_i[i]] with zero cycles of latency.
  - If ZERO_REG=1 and the address is 0, the result is 0 regardless of stored state.
  - Any number of ports may read the same address.
- Write:
  - When wr_en_i[j]=1, mem[wr_addr_i[j]] <= wr_data_i[j] at the rising edge. The new value is visible on reads from the next cycle.
  - Writes to address 0 are dropped when ZERO_REG=1.
  - When several enabled ports target the same address, the highest port index wins. Other writes in that cycle still complete.
- Scoreboard:
  - busy[a] is set at the edge where sb_set_i=1 and sb_addr_i=a.
  - busy[a] is cleared at the edge where any enabled write port targets a.
  - Set and clear of the same register in one cycle: set wins, because the new issue supersedes the older writeback.
  - flush_i=1 clears all busy bits. flush_i and sb_set_i in the same cycle: the flush applies first, then the set is honoured, leaving only that bit busy.
  - With ZERO_REG=1, busy[0] is held at 0.
- No state machine: per-register data plus busy flops form DEPTH independent 2-state (idle/busy) machines with the transitions above.

Optional Feature:
- REGFILE_BYPASS_EN defined: write-to-read forwarding.
  - If an enabled write targets rd_addr_i[i] (non-zero when ZERO_REG=1), rd_data_o[i] returns that write data in the same cycle, using the highest-index write on conflict.
  - rd_busy_o[i] reads 0 when a same-cycle write clears the register and no same-cycle sb_set_i targets it.
- Not defined: reads return the stored value until after the edge; rd_busy_o reflects registered state only.

Decomposition:
- Package regfile_pkg: default XLEN/DEPTH constants, and a helper function that resolves the winning write port for a given address (highest index), shared by the write logic and the bypass logic.
- One sub-module, regfile_scoreboard: DEPTH busy bits with set/clear/flush/reset priority and NUM_RD busy lookups.
- regfile_mp instantiates regfile_scoreboard alongside the storage array.

Test Plan:
- Reset and x0:
  - Stimulus: rst=1 for 1 cycle, then read all addresses; then write 0xDEADBEEF to x0.
  - Required: all reads 0, all busy bits 0; x0 still reads 0 and rd_busy for x0 is 0.
- Basic write/read:
  - Stimulus: write x1=0x11112222 and x2=0x33334444 (NUM_WR=2, same cycle).
  - Required: next cycle ports 0/1 read 0x11112222/0x33334444; a disabled write of 0xFFFFFFFF to x3 leaves x3=0.
- Write conflict:
  - Stimulus: ports 0 and 1 both write x5, with 0xAAAA0000 and 0xBBBB0000.
  - Required: x5 reads 0xBBBB0000.
- Scoreboard:
  - Stimulus: sb_set x7, then next cycle a write to x7.
  - Required: busy=1 after the set, 0 after the write.
  - Stimulus: set and write x7 in the same cycle.
  - Required: busy=1.
  - Stimulus: flush together with sb_set x9 while x7 is busy.
  - Required: only x9 busy.
- Bypass:
  - Stimulus: same-cycle write x4=0x12345678 while reading x4.
  - Required with REGFILE_BYPASS_EN: 0x12345678 in the same cycle.
  - Required without it: the old value, then 0x12345678 next cycle.
- Reset mid-operation:
  - Stimulus: rst together with a write x6=0x55 and sb_set x6.
  - Required: x6=0 and busy=0 afterwards.
